// File: rtl/sfilt_pkg.sv
// Shared definitions for the multi-channel MAC filter engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Provides command codes and the per-stage control record.
package sfilt_pkg;

  // Field widths in the stage record are sized for the largest supported
  // configuration (NCH up to 16, shift field up to 8 bits); narrower
  // configurations zero-extend into them.
  localparam int CH_MAXW = 4;
  localparam int SH_MAXW = 8;

  typedef enum logic [1:0] {
    CMD_MUL = 2'd0,
    CMD_MAC = 2'd1,
    CMD_SHR = 2'd2,
    CMD_OUT = 2'd3
  } cmd_e;

  // Control that travels alongside the product through the multiplier.
  typedef struct packed {
    logic               vld;
    cmd_e               cmd;
    logic [CH_MAXW-1:0] ch;
    logic [SH_MAXW-1:0] shamt;
  } stage_t;

endpackage

// File: rtl/sfilt_mc_if.sv
// Command/result bus between the sequencer and sfilt_mc.
// Ports: pushin/cmd/ch/q/h (sequencer -> engine), pushout/z/zch (engine -> sequencer).
// Backpressure: none; the engine accepts a command every cycle.
interface sfilt_mc_if #(
  parameter int DW  = 32,
  parameter int CHW = 2
);
  logic                 pushin;
  logic [1:0]           cmd;
  logic [CHW-1:0]       ch;
  logic signed [DW-1:0] q;
  logic signed [DW-1:0] h;
  logic                 pushout;
  logic [DW-1:0]        z;
  logic [CHW-1:0]       zch;

  modport master (output pushin, cmd, ch, q, h, input pushout, z, zch);
  modport slave  (input pushin, cmd, ch, q, h, output pushout, z, zch);
endinterface

// File: rtl/sfilt_mul_pipe.sv
// Signed DW x DW multiplier with STAGES pipeline registers; control record rides along.
// Ports: clk, rst (sync, active-high, clears control chain), a/b operands, meta_in; prod/meta_out.
// Latency: STAGES cycles. Backpressure: none, one operation per cycle.
import sfilt_pkg::*;

module sfilt_mul_pipe #(
  parameter int DW     = 32,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  input  stage_t                 meta_in,
  output logic signed [2*DW-1:0] prod,
  output stage_t                 meta_out
);

  logic signed [2*DW-1:0] prod_c;
  logic signed [2*DW-1:0] p_r [STAGES];
  stage_t                 m_r [STAGES];

  // Operands are sign-extended to the full product width by the signed context.
  assign prod_c = a * b;

  // Product registers carry no reset: only the valid chain matters for flushing.
  always_ff @(posedge clk) begin
    p_r[0] <= prod_c;
    for (int i = 1; i < STAGES; i++) p_r[i] <= p_r[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) m_r[i] <= '0;
    end else begin
      m_r[0] <= meta_in;
      for (int i = 1; i < STAGES; i++) m_r[i] <= m_r[i-1];
    end
  end

  assign prod     = p_r[STAGES-1];
  assign meta_out = m_r[STAGES-1];

endmodule

// File: rtl/sfilt_mc.sv
// Multi-channel MAC filter engine: mul, mul-acc, shift-right-round, output-and-clear per channel.
// Ports: clk, rst (sync, active-high), bus (sfilt_mc_if.slave). Optional macro SFILT_SAT_EN
// saturates output to signed DW range. Latency: cmd 3 -> pushout MUL_STAGES+3 cycles. No backpressure.
import sfilt_pkg::*;

module sfilt_mc #(
  parameter int DW         = 32,
  parameter int NCH        = 4,
  parameter int MUL_STAGES = 2,
  parameter int SHW        = 7
) (
  input  logic       clk,
  input  logic       rst,
  sfilt_mc_if.slave  bus
);

  localparam int ACCW = 2 * DW;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_MAXW:0] NCH_L = (CH_MAXW+1)'(NCH);

  // Input register
  stage_t               in_r;
  logic signed [DW-1:0] q_r, h_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_r <= '0;
    end else begin
      in_r.vld   <= bus.pushin;
      in_r.cmd   <= cmd_e'(bus.cmd);
      in_r.ch    <= CH_MAXW'(bus.ch);
      in_r.shamt <= SH_MAXW'(bus.h[SHW-1:0]);
    end
    q_r <= bus.q;
    h_r <= bus.h;
  end

  // Multiplier pipeline
  logic signed [ACCW-1:0] mp_prod;
  stage_t                 mp_meta;

  sfilt_mul_pipe #(.DW(DW), .STAGES(MUL_STAGES)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .a        (q_r),
    .b        (h_r),
    .meta_in  (in_r),
    .prod     (mp_prod),
    .meta_out (mp_meta)
  );

  // Execute stage: single read-modify-write of acc[ch] per cycle, so a
  // command always observes the previous command's result on that channel.
  logic signed [ACCW-1:0] acc [NCH];
  logic [CHW-1:0]         ex_sel;
  logic                   ch_ok;
  logic signed [ACCW-1:0] acc_cur;
  logic signed [ACCW:0]   shr_ext;
  logic [ACCW-1:0]        shr_res;
  logic [DW-1:0]          z_sel;

  assign ex_sel  = mp_meta.ch[CHW-1:0];
  assign ch_ok   = {1'b0, mp_meta.ch} < NCH_L;
  assign acc_cur = acc[ex_sel];

  // Shift with one guard bit appended; the bit shifted into the guard
  // position is the rounding increment. Large shifts collapse to 0 for
  // both signs (all ones + 1, or all zeros).
  assign shr_ext = $signed({acc_cur, 1'b0}) >>> mp_meta.shamt;
  assign shr_res = shr_ext[ACCW:1] + {{(ACCW-1){1'b0}}, shr_ext[0]};

`ifdef SFILT_SAT_EN
  // In range iff bits [ACCW-1:DW-1] are all equal to the sign.
  logic [ACCW-DW:0] acc_hi;
  assign acc_hi = acc_cur[ACCW-1:DW-1];
  assign z_sel  = (&acc_hi || ~|acc_hi) ? acc_cur[DW-1:0]
                : {acc_cur[ACCW-1], {(DW-1){~acc_cur[ACCW-1]}}};
`else
  assign z_sel = acc_cur[DW-1:0];
`endif

  logic           ex_vld;
  logic [DW-1:0]  ex_z;
  logic [CHW-1:0] ex_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      ex_vld <= 1'b0;
      ex_z   <= '0;
      ex_ch  <= '0;
    end else begin
      ex_vld <= 1'b0;
      if (mp_meta.vld && ch_ok) begin
        case (mp_meta.cmd)
          CMD_MUL: acc[ex_sel] <= mp_prod;
          CMD_MAC: acc[ex_sel] <= acc_cur + mp_prod;
          CMD_SHR: acc[ex_sel] <= shr_res;
          CMD_OUT: begin
            ex_vld      <= 1'b1;
            ex_z        <= z_sel;
            ex_ch       <= ex_sel;
            acc[ex_sel] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register: z/zch hold until the next output command.
  logic           pushout_r;
  logic [DW-1:0]  z_r;
  logic [CHW-1:0] zch_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pushout_r <= 1'b0;
      z_r       <= '0;
      zch_r     <= '0;
    end else begin
      pushout_r <= ex_vld;
      if (ex_vld) begin
        z_r   <= ex_z;
        zch_r <= ex_ch;
      end
    end
  end

  assign bus.pushout = pushout_r;
  assign bus.z       = z_r;
  assign bus.zch     = zch_r;

endmodule

// File: tb/tb_sfilt_mc.sv
// Directed self-checking bench for sfilt_mc: one default instance (NCH=4) and one with NCH=3.
// Outputs are collected on the falling edge into per-instance queues with a timestamp.
// Expected values are hand-computed constants; SFILT_SAT_EN selects the saturating expectations.
import sfilt_pkg::*;

module tb_sfilt_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfilt_mc_if #(.DW(32), .CHW(2)) bus_a ();
  sfilt_mc_if #(.DW(32), .CHW(2)) bus_b ();

  sfilt_mc #(.DW(32), .NCH(4), .MUL_STAGES(2), .SHW(7)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  sfilt_mc #(.DW(32), .NCH(3), .MUL_STAGES(2), .SHW(7)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Command sampled at rising edge k; pushout is visible after edge k+4,
  // i.e. at the 5th falling edge counted from edge k.
  localparam int LAT = 5;

  typedef struct packed {
    logic [31:0] z;
    logic [1:0]  zch;
    logic [31:0] t;
  } out_t;

  out_t qa[$];
  out_t qb[$];
  int   ncyc   = 0;
  int   last_t = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    ncyc++;
    if (bus_a.pushout === 1'b1) qa.push_back({bus_a.z, bus_a.zch, 32'(ncyc)});
    if (bus_b.pushout === 1'b1) qb.push_back({bus_b.z, bus_b.zch, 32'(ncyc)});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit b, input logic [1:0] c, input logic [1:0] chn,
                      input logic [31:0] qv, input logic [31:0] hv);
    if (!b) begin
      bus_a.pushin = 1'b1; bus_a.cmd = c; bus_a.ch = chn; bus_a.q = qv; bus_a.h = hv;
    end else begin
      bus_b.pushin = 1'b1; bus_b.cmd = c; bus_b.ch = chn; bus_b.q = qv; bus_b.h = hv;
    end
    @(posedge clk);
    last_t = ncyc;
    #1;
    bus_a.pushin = 1'b0;
    bus_b.pushin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops one recorded output (if any) and checks it; caller checks the count.
  task automatic take(input bit b, input string tag, input logic [31:0] ez,
                      input logic [1:0] ezch, output int t);
    out_t o;
    t = -1;
    if (b ? (qb.size() != 0) : (qa.size() != 0)) begin
      o = b ? qb.pop_front() : qa.pop_front();
      chk({tag, " z"}, 64'(o.z), 64'(ez));
      chk({tag, " zch"}, 64'(o.zch), 64'(ezch));
      t = int'(o.t);
    end
  endtask

  int t0, t1, t2;
  int av  [4] = '{11, -11, 5, -1};
  int shv [4] = '{2, 2, 0, 100};
  int ez3 [4] = '{3, -3, 5, 0};

  initial begin
    bus_a.pushin = 1'b0; bus_a.cmd = '0; bus_a.ch = '0; bus_a.q = '0; bus_a.h = '0;
    bus_b.pushin = 1'b0; bus_b.cmd = '0; bus_b.ch = '0; bus_b.q = '0; bus_b.h = '0;
    rst = 1'b1;
    idle(3);
    chk("reset pushout", 64'(bus_a.pushout), 64'd0);
    chk("reset z", 64'(bus_a.z), 64'd0);
    chk("reset zch", 64'(bus_a.zch), 64'd0);
    rst = 1'b0;
    idle(2);

    // 1: 3*5 + (-2*4) = 7 on ch0, back-to-back
    qa.delete();
    send(0, CMD_MUL, 0, 3, 5);
    send(0, CMD_MAC, 0, -2, 4);
    send(0, CMD_OUT, 0, 0, 0);
    t0 = last_t;
    idle(10);
    chk("t1 count", 64'(qa.size()), 64'd1);
    take(0, "t1", 32'd7, 2'd0, t1);
    chk("t1 latency", 64'(t1 - t0), 64'(LAT));

    // 2: interleaved channels, consecutive pushouts
    send(0, CMD_MUL, 1, 100, 100);
    send(0, CMD_MUL, 2, -1, 1);
    send(0, CMD_MAC, 1, 1, 1);
    send(0, CMD_OUT, 1, 0, 0);
    t0 = last_t;
    send(0, CMD_OUT, 2, 0, 0);
    idle(10);
    chk("t2 count", 64'(qa.size()), 64'd2);
    take(0, "t2a", 32'd10001, 2'd1, t1);
    take(0, "t2b", 32'hFFFF_FFFF, 2'd2, t2);
    chk("t2 latency", 64'(t1 - t0), 64'(LAT));
    chk("t2 spacing", 64'(t2 - t1), 64'd1);

    // 3: shift right with round-half-up
    for (int i = 0; i < 4; i++) begin
      send(0, CMD_MUL, 0, av[i], 1);
      send(0, CMD_SHR, 0, 0, shv[i]);
      send(0, CMD_OUT, 0, 0, 0);
    end
    idle(10);
    chk("t3 count", 64'(qa.size()), 64'd4);
    for (int i = 0; i < 4; i++) take(0, $sformatf("t3_%0d", i), ez3[i], 2'd0, t1);

    // 4: values beyond the DW range, and right at its edge
    send(0, CMD_MUL, 3, 32'h0010_0000, 32'h0010_0000);
    send(0, CMD_OUT, 3, 0, 0);
    send(0, CMD_MUL, 3, -32'sh0010_0000, 32'h0010_0000);
    send(0, CMD_OUT, 3, 0, 0);
    send(0, CMD_MUL, 3, 32'h7FFF_FFFF, 1);
    send(0, CMD_OUT, 3, 0, 0);
    send(0, CMD_MUL, 3, 32'h0001_0000, 32'h0000_8000);
    send(0, CMD_OUT, 3, 0, 0);
    idle(10);
    chk("t4 count", 64'(qa.size()), 64'd4);
`ifdef SFILT_SAT_EN
    take(0, "t4 pos2^40", 32'h7FFF_FFFF, 2'd3, t1);
    take(0, "t4 neg2^40", 32'h8000_0000, 2'd3, t1);
    take(0, "t4 max", 32'h7FFF_FFFF, 2'd3, t1);
    take(0, "t4 max+1", 32'h7FFF_FFFF, 2'd3, t1);
`else
    take(0, "t4 pos2^40", 32'h0, 2'd3, t1);
    take(0, "t4 neg2^40", 32'h0, 2'd3, t1);
    take(0, "t4 max", 32'h7FFF_FFFF, 2'd3, t1);
    take(0, "t4 max+1", 32'h8000_0000, 2'd3, t1);
`endif

    // 5: reset while commands are in flight
    send(0, CMD_MUL, 0, 9, 9);
    send(0, CMD_OUT, 0, 0, 0);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    chk("t5 flushed count", 64'(qa.size()), 64'd0);
    send(0, CMD_OUT, 0, 0, 0);
    idle(10);
    chk("t5 after count", 64'(qa.size()), 64'd1);
    take(0, "t5", 32'd0, 2'd0, t1);

    // 6: out-of-range channel on the NCH=3 instance
    send(1, CMD_MUL, 0, 1, 1);
    send(1, CMD_MUL, 1, 2, 1);
    send(1, CMD_MUL, 2, 3, 1);
    send(1, CMD_MUL, 3, 7, 7);
    send(1, CMD_MAC, 3, 7, 7);
    send(1, CMD_OUT, 3, 0, 0);
    idle(10);
    chk("t6 dropped count", 64'(qb.size()), 64'd0);
    send(1, CMD_OUT, 0, 0, 0);
    send(1, CMD_OUT, 1, 0, 0);
    send(1, CMD_OUT, 2, 0, 0);
    idle(10);
    chk("t6 count", 64'(qb.size()), 64'd3);
    take(1, "t6 ch0", 32'd1, 2'd0, t1);
    take(1, "t6 ch1", 32'd2, 2'd1, t1);
    take(1, "t6 ch2", 32'd3, 2'd2, t1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
